// File: rtl/register_reader.sv
// Nibble-serial readback of the DMA generator's internal registers.
// Snapshots one source on request and streams it LSB nibble first.
module register_reader #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_req,
  input  logic [1:0]          rd_sel,
  input  logic [4*DATA_W-1:0] src_data,
  output logic                rd_busy,
  output logic [3:0]          do_nib,
  output logic                do_valid,
  output logic                do_last,
  output logic                oe,
  input  logic                do_ack
);

  localparam int NIB = DATA_W / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0][DATA_W-1:0] src;
  logic [NIB-1:0][3:0]    snap;
  logic [IW-1:0]          idx;
  logic                   take;
  logic                   done;
  logic                   at_last;

  assign src     = src_data;
  assign at_last = (idx == LAST);
  assign take    = (state == IDLE) && rd_req;
  assign done    = (state == SEND) && do_ack && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (rd_req) state_nxt = SEND;
      SEND: if (done)   state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // Snapshot is frozen for the whole transfer; idx only moves on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap <= '0;
      idx  <= '0;
    end else if (take) begin
      snap <= src[rd_sel];
      idx  <= '0;
    end else if (state == SEND && do_ack) begin
      if (at_last) begin
        idx <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

  always_comb begin
    rd_busy  = 1'b0;
    do_valid = 1'b0;
    oe       = 1'b0;
    do_last  = 1'b0;
    do_nib   = 4'h0;
    unique case (state)
      SEND: begin
        rd_busy  = 1'b1;
        do_valid = 1'b1;
        oe       = 1'b1;
        do_last  = at_last;
        do_nib   = snap[idx];
      end
      default: ;
    endcase
  end

endmodule

// File: doc/register_reader.md
# register_reader

Readback path for the DMA generator's 8-bit internal registers (control, word count, address, word-count reload) onto the 4-bit nibble data bus. On a read request, the block snapshots the selected register and presents it nibble by nibble, least-significant first, under a valid/ack handshake with output enable. It complements the parallel-load write path: writes land nibble data in registers, and this block returns register contents to the bus.

## Interface
Parameters:
- DATA_W, 8: width of each source register. Must be a multiple of 4 and at least 4. NIB = DATA_W/4 nibbles per transfer.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_req  in  1  read request, sampled only in IDLE
- rd_sel  in  2  source select: 0 control, 1 word count, 2 address, 3 reload
- src_data  in  4*DATA_W  flattened sources; source k occupies bits [k*DATA_W +: DATA_W]
- rd_busy  out  1  transfer in progress
- do_nib  out  4  nibble driven to the data bus
- do_valid  out  1  do_nib holds valid data
- do_last  out  1  current nibble is the final one
- oe  out  1  bus output enable; equals do_valid
- do_ack  in  1  consumer accepts the current nibble

## Operation
- States: IDLE and SEND.
- IDLE:
  - rd_busy, do_valid, oe and do_last are 0; do_nib is 0.
  - If rd_req=1 at a rising edge, capture src_data[rd_sel] into the snapshot, set nibble index to 0, and enter SEND.
- SEND:
  - do_valid=oe=rd_busy=1.
  - do_nib = snapshot[4*idx +: 4].
  - do_last = (idx == NIB-1).
- Handshake: a nibble completes on a rising edge where do_valid=1 and do_ack=1.
  - Without ack, do_nib, do_last and idx hold.
  - Non-final nibble completes: idx increments.
  - Final nibble completes: return to IDLE and clear idx.
- Source changes after capture do not affect the transfer in progress.
- rd_req and rd_sel are ignored while in SEND; there is no queuing.
- do_ack is ignored in IDLE.
- Simultaneous events:
  - If the final ack and rd_req fall in the same cycle, the block goes to IDLE and the request is not taken.
  - A requester holding rd_req high is captured on the following edge.
- idx never exceeds NIB-1; no wrap-around beyond the final nibble.

## Timing
- Reset: all outputs are 0, state is IDLE, and snapshot and idx are cleared. Reset takes effect immediately (asynchronous) and aborts any transfer mid-stream; no further nibbles are presented.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Latency:
  - rd_req sampled at edge E: do_valid=1 and do_nib = nibble 0 after edge E.
  - With do_ack held high, nibble k is presented after edge E+k.
  - do_valid falls after edge E+NIB.
- Minimum request-to-request spacing: NIB+1 cycles, since one IDLE cycle is mandatory.
- Back-pressure: each do_ack=0 cycle during SEND stretches the transfer by exactly one cycle.

## Test plan
- Reset values:
  - Assert rst_n=0 mid-SEND after nibble 0 is accepted: outputs go to 0 immediately.
  - After release, do_valid stays 0 until a new rd_req.
- Basic read:
  - Setup: src address=8'hA5, rd_sel=2, one-cycle rd_req, do_ack held 1.
  - Required: do_nib=4'h5 (do_last=0), then 4'hA (do_last=1), then do_valid=0.
- Back-pressure:
  - Setup: word count=8'h3C, do_ack=0 for 3 cycles, then 1.
  - Required: 4'hC held 4 cycles with oe=1, then 4'h3.
- Snapshot coherence:
  - Setup: read control=8'h12, then change src control to 8'hFE after the capture edge.
  - Required: bus still shows 4'h2 then 4'h1.
- Ignored request:
  - Setup: pulse rd_req with rd_sel=3 during SEND of source 0.
  - Required: the transfer completes unchanged and no second transfer starts.
- Held request at the final ack:
  - Setup: hold rd_req=1 with rd_sel=1 across the final ack.
  - Required: exactly one IDLE cycle, then a new transfer of word count starting with its low nibble.
